// File: rtl/z80_wait_controller.sv
// Programmable per-device Z80 wait-state generator with READY extension and a sticky timeout.
// Config bytes and status sit on a small I/O register window; o_wait drives the WAIT_n buffer.
module z80_wait_controller #(
  parameter int unsigned NUM_DEV  = 4,
  parameter int unsigned WS_WIDTH = 4,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned DEV_W    = $clog2(NUM_DEV),
  parameter int unsigned ADDR_W   = DEV_W + 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_cs_n,
  input  logic              i_wr_n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_data,
  output logic [7:0]        o_data,
  input  logic              i_iorq_n,
  input  logic              i_mreq_n,
  input  logic [DEV_W-1:0]  i_device,
  input  logic              i_ready,
  output logic              o_wait,
  output logic              o_timeout
);

  // Config storage is padded to a power of two so any i_device value indexes safely;
  // slots at or above NUM_DEV are never written and stay zero.
  localparam int unsigned DevSlots = 1 << DEV_W;
  localparam int unsigned TcntW    = $clog2(TIMEOUT + 1);
  localparam logic [7:0]  CfgMask  = 8'hC0 | 8'((1 << WS_WIDTH) - 1);

  typedef enum logic [1:0] {StIdle, StCount, StExtend, StDone} state_e;

  logic [7:0]          cfg_q [DevSlots];
  logic [7:0]          cfg_d [DevSlots];
  state_e              state_q, state_d;
  logic [WS_WIDTH-1:0] cnt_q, cnt_d;
  logic [TcntW-1:0]    tcnt_q, tcnt_d;
  logic                rdy_en_q, rdy_en_d;
  logic [DEV_W-1:0]    dev_q, dev_d;
  logic                to_q, to_d;
  logic [DEV_W-1:0]    to_dev_q, to_dev_d;
  logic                req_q;

  logic                req, trig, wr_en, cfg_hit, stat_hit;
  logic [WS_WIDTH-1:0] n_sel;
  logic                rdy_sel;
  logic [2:0]          status_dev;

  assign wr_en      = ~i_cs_n & ~i_wr_n;
  assign cfg_hit    = i_addr < ADDR_W'(NUM_DEV);
  assign stat_hit   = i_addr == ADDR_W'(NUM_DEV);
  assign req        = ~i_iorq_n | (~i_mreq_n & cfg_q[i_device][6]);
  assign trig       = req & ~req_q;
  assign n_sel      = cfg_q[i_device][WS_WIDTH-1:0];
  assign rdy_sel    = cfg_q[i_device][7];
  assign status_dev = 3'(to_dev_q);

  always_comb begin
    for (int i = 0; i < DevSlots; i++) begin
      cfg_d[i] = cfg_q[i];
      if (wr_en && cfg_hit && (i_addr[DEV_W-1:0] == DEV_W'(i))) begin
        cfg_d[i] = i_data & CfgMask;
      end
    end
  end

  always_comb begin
    o_data = 8'h00;
    if (cfg_hit) begin
      o_data = cfg_q[i_addr[DEV_W-1:0]];
    end else if (stat_hit) begin
      o_data = {to_q, 4'b0000, status_dev};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    rdy_en_d = rdy_en_q;
    dev_d    = dev_q;
    to_d     = to_q;
    to_dev_d = to_dev_q;

    // Clear first so a timeout landing on the same clock takes priority.
    if (wr_en && stat_hit) begin
      to_d = 1'b0;
    end

    if (!req) begin
      state_d = StIdle;
      cnt_d   = '0;
      tcnt_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trig) begin
            dev_d    = i_device;
            rdy_en_d = rdy_sel;
            tcnt_d   = '0;
            if (n_sel != '0) begin
              state_d = StCount;
              cnt_d   = n_sel;
            end else if (rdy_sel) begin
              state_d = StExtend;
            end else begin
              state_d = StDone;
            end
          end
        end
        StCount: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == WS_WIDTH'(1)) begin
            tcnt_d  = '0;
            state_d = rdy_en_q ? StExtend : StDone;
          end
        end
        StExtend: begin
          if (i_ready) begin
            state_d = StDone;
          end else if (tcnt_q == TcntW'(TIMEOUT - 1)) begin
            state_d  = StDone;
            to_d     = 1'b1;
            to_dev_d = dev_q;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DevSlots; i++) begin
        cfg_q[i] <= 8'h00;
      end
      state_q  <= StIdle;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      rdy_en_q <= 1'b0;
      dev_q    <= '0;
      to_q     <= 1'b0;
      to_dev_q <= '0;
      req_q    <= 1'b0;
    end else begin
      for (int i = 0; i < DevSlots; i++) begin
        cfg_q[i] <= cfg_d[i];
      end
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      rdy_en_q <= rdy_en_d;
      dev_q    <= dev_d;
      to_q     <= to_d;
      to_dev_q <= to_dev_d;
      req_q    <= req;
    end
  end

  assign o_wait    = req & ((state_q == StCount) | (state_q == StExtend));
  assign o_timeout = to_q;

endmodule

// File: tb/tb_z80_wait_controller.sv
// Bench for z80_wait_controller: directed scenarios plus random traffic checked every cycle
// against a cycles-since-request model of the wait/extension/timeout rules.
module tb_z80_wait_controller;

  localparam int NUM_DEV  = 4;
  localparam int WS_WIDTH = 4;
  localparam int TIMEOUT  = 64;
  localparam logic [7:0] MASK = 8'hCF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;
  logic [2:0] addr = '0;
  logic [7:0] data = '0;
  logic [7:0] o_data;
  logic       iorq_n = 1'b1;
  logic       mreq_n = 1'b1;
  logic [1:0] device = '0;
  logic       ready = 1'b0;
  logic       o_wait;
  logic       o_timeout;

  int vectors = 0;
  int miscompares = 0;

  z80_wait_controller #(
    .NUM_DEV (NUM_DEV),
    .WS_WIDTH(WS_WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .i_cs_n   (cs_n),
    .i_wr_n   (wr_n),
    .i_addr   (addr),
    .i_data   (data),
    .o_data   (o_data),
    .i_iorq_n (iorq_n),
    .i_mreq_n (mreq_n),
    .i_device (device),
    .i_ready  (ready),
    .o_wait   (o_wait),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  // Model: k counts cycles since the request's first cycle (k=1 is the cycle after trig).
  // Waits cover k in 1..N, then extension cycles N+1..N+TIMEOUT until READY is seen.
  logic [7:0] m_cfg [NUM_DEV];
  bit         m_to;
  logic [1:0] m_to_dev;
  logic [1:0] m_dev;
  bit         m_req_prev;
  bit         m_rdy;
  bit         m_seen;
  int         m_n;
  int         m_k;

  task automatic model_reset();
    for (int i = 0; i < NUM_DEV; i++) m_cfg[i] = 8'h00;
    m_to = 0; m_to_dev = '0; m_dev = '0; m_req_prev = 0;
    m_rdy = 0; m_seen = 0; m_n = 0; m_k = 0;
  endtask

  function automatic bit model_req();
    return (!iorq_n) || (!mreq_n && m_cfg[device][6]);
  endfunction

  function automatic bit exp_wait();
    bit r;
    r = model_req();
    if (!rst_n || !r || !m_req_prev) return 0;
    if (m_k <= m_n) return 1;
    return m_rdy && (m_k <= m_n + TIMEOUT) && !m_seen;
  endfunction

  function automatic logic [7:0] exp_data();
    if (addr < 3'd4) return m_cfg[addr[1:0]];
    if (addr == 3'd4) return {m_to, 4'b0000, 1'b0, m_to_dev};
    return 8'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    bit r, set_to;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        r = model_req();
        set_to = 0;
        if (r) begin
          if (!m_req_prev) begin
            m_n = int'(m_cfg[device][3:0]);
            m_rdy = m_cfg[device][7];
            m_dev = device;
            m_k = 1;
            m_seen = 0;
          end else begin
            if (m_rdy && m_k > m_n && m_k <= m_n + TIMEOUT && !m_seen) begin
              if (ready) m_seen = 1;
              else if (m_k == m_n + TIMEOUT) set_to = 1;
            end
            m_k++;
          end
        end
        m_req_prev = r;
        if (!cs_n && !wr_n) begin
          if (addr < 3'd4) m_cfg[addr[1:0]] = data & MASK;
          else if (addr == 3'd4) m_to = 0;
        end
        if (set_to) begin
          m_to = 1;
          m_to_dev = m_dev;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("o_wait", 32'(o_wait), 32'(exp_wait()));
      chk("o_timeout", 32'(o_timeout), 32'(m_to));
      chk("o_data", 32'(o_data), 32'(exp_data()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cs_n = 0; wr_n = 0; addr = a; data = d;
    tick();
    cs_n = 1; wr_n = 1;
  endtask

  task automatic io_cycle(input bit mem, input logic [1:0] dev, input int len, input int rdy_at,
                          output int waits, output logic [31:0] pat);
    waits = 0;
    pat = '0;
    device = dev;
    if (mem) mreq_n = 0;
    else iorq_n = 0;
    for (int i = 0; i < len; i++) begin
      ready = (i >= rdy_at);
      @(negedge clk);
      if (o_wait === 1'b1) begin
        waits++;
        if (i < 32) pat[i] = 1'b1;
      end
      tick();
    end
    iorq_n = 1; mreq_n = 1; ready = 0;
  endtask

  initial begin
    int w;
    logic [31:0] p;

    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_wait", 32'(o_wait), 0);
    chk("rst_timeout", 32'(o_timeout), 0);
    for (int a = 0; a <= NUM_DEV; a++) begin
      addr = 3'(a);
      #1 chk("rst_read", 32'(o_data), 0);
    end
    tick();

    wr(3'd1, 8'h03);
    io_cycle(0, 2'd1, 6, 1000, w, p);
    chk("n3_count", 32'(w), 3);
    chk("n3_pattern", {26'b0, p[5:0]}, 32'b001110);
    addr = 3'd1;
    #1 chk("n3_readback", 32'(o_data), 32'h03);
    tick();
    wr(3'd0, 8'hFF);
    addr = 3'd0;
    #1 chk("unused_bits", 32'(o_data), 32'hCF);
    tick();

    wr(3'd2, 8'h41);
    io_cycle(1, 2'd2, 4, 1000, w, p);
    chk("mem_en_wait", 32'(w), 1);
    tick();
    wr(3'd2, 8'h01);
    io_cycle(1, 2'd2, 4, 1000, w, p);
    chk("mem_dis_wait", 32'(w), 0);
    tick();
    io_cycle(0, 2'd2, 4, 1000, w, p);
    chk("io_wait_dev2", 32'(w), 1);
    tick();

    wr(3'd0, 8'h82);
    io_cycle(0, 2'd0, 10, 7, w, p);
    chk("ready_ext_count", 32'(w), 7);
    chk("ready_ext_pattern", {22'b0, p[9:0]}, 32'h0FE);
    tick();

    wr(3'd3, 8'h80);
    io_cycle(0, 2'd3, 70, 1000, w, p);
    chk("timeout_wait", 32'(w), 64);
    chk("timeout_flag", 32'(o_timeout), 1);
    addr = 3'd4;
    #1 chk("status_read", 32'(o_data), 32'h83);
    tick();
    wr(3'd4, 8'h00);
    chk("timeout_clear", 32'(o_timeout), 0);

    wr(3'd1, 8'h0F);
    io_cycle(0, 2'd1, 4, 1000, w, p);
    chk("abort_waits", 32'(w), 3);
    #1 chk("abort_drop", 32'(o_wait), 0);
    tick();
    io_cycle(0, 2'd1, 18, 1000, w, p);
    chk("fresh_15", 32'(w), 15);
    tick();

    device = 2'd1;
    iorq_n = 0;
    repeat (3) tick();
    chk("wait_before_reset", 32'(o_wait), 1);
    #3 rst_n = 0;
    #1 chk("reset_wait", 32'(o_wait), 0);
    addr = 3'd1;
    #1 chk("reset_cfg", 32'(o_data), 0);
    iorq_n = 1;
    @(posedge clk);
    #2 rst_n = 1;
    tick();

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(19) == 0) iorq_n = ~iorq_n;
      if ($urandom_range(19) == 0) mreq_n = ~mreq_n;
      if ($urandom_range(7) == 0) device = 2'($urandom_range(3));
      ready = ($urandom_range((c % 500) < 250 ? 199 : 5) == 0);
      addr = 3'($urandom_range(7));
      if ($urandom_range(11) == 0) begin
        cs_n = 0; wr_n = 0; data = 8'($urandom);
      end else begin
        cs_n = 1'($urandom_range(1)); wr_n = 1;
      end
      tick();
    end
    cs_n = 1; wr_n = 1; iorq_n = 1; mreq_n = 1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
